// File: rtl/threshold_block_read_scheduler.sv
// threshold_block_read_scheduler
// Drains completed threshold-cutter blocks from the AXI block RAM.
// Block-start requests are queued in a small FIFO. Each block is read as a
// series of INCR bursts, and its beats are passed through to a valid/ready
// consumer. block_done pulses once for every block that finishes.
module threshold_block_read_scheduler #(
    parameter int           BLOCK_DEPTH   = 400,
    parameter int           DATA_WIDTH    = 256,
    parameter int           MAX_BURST     = 256,
    parameter int           BEAT_ADDR_INC = 1,
    parameter int           REQ_FIFO_IDX  = 2,
    parameter logic [3:0]   AXI_ID        = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_start,
    input  logic [31:0]           read_addr_start,
    input  logic                  rsta_busy,
    input  logic                  rstb_busy,
    output logic [3:0]            m_axi_arid,
    output logic [31:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  block_done,
    output logic                  busy,
    output logic                  req_overflow,
    output logic                  resp_err
);

    localparam int CNT_W      = $clog2(BLOCK_DEPTH + 1);
    localparam int FIFO_DEPTH = 1 << REQ_FIFO_IDX;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, AR, R_DATA, DONE} state_t;

    localparam cnt_t DEPTH_C = cnt_t'(BLOCK_DEPTH);

    // A burst never exceeds the AXI/BRAM limit; the last burst of a block is shorter
    function automatic cnt_t burst_of(input cnt_t rem);
        if (int'(rem) > MAX_BURST) begin
            return cnt_t'(MAX_BURST);
        end
        return rem;
    endfunction

    state_t                state;
    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [REQ_FIFO_IDX:0] wr_ptr;
    logic [REQ_FIFO_IDX:0] rd_ptr;
    logic [31:0]           cur_addr;
    cnt_t                  remaining;
    cnt_t                  burst;
    cnt_t                  beat_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  beat_hs;
    cnt_t                  beat_next;
    cnt_t                  rem_next;
    cnt_t                  next_burst;
    cnt_t                  first_burst;
    logic [31:0]           addr_next;
    logic [31:0]           fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[REQ_FIFO_IDX] != rd_ptr[REQ_FIFO_IDX]) &&
                        (wr_ptr[REQ_FIFO_IDX-1:0] == rd_ptr[REQ_FIFO_IDX-1:0]);
    assign push       = read_start && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty && !rsta_busy && !rstb_busy;
    assign fifo_head  = fifo_mem[rd_ptr[REQ_FIFO_IDX-1:0]];

    assign beat_hs     = (state == R_DATA) && m_axi_rvalid && out_ready;
    assign beat_next   = beat_cnt + cnt_t'(1);
    assign rem_next    = remaining - burst;
    assign next_burst  = burst_of(rem_next);
    assign first_burst = burst_of(DEPTH_C);
    assign addr_next   = cur_addr + 32'(burst) * 32'(BEAT_ADDR_INC);

    assign m_axi_arid    = AXI_ID;
    assign m_axi_arsize  = 3'b101;
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (state == R_DATA) && out_ready;
    assign out_valid     = (state == R_DATA) && m_axi_rvalid;
    assign out_data      = (state == R_DATA) ? m_axi_rdata : '0;
    assign out_last      = (state == R_DATA) && m_axi_rvalid && m_axi_rlast && (remaining == burst);
    assign busy          = (state != IDLE) || !fifo_empty;

    // Request storage; the payload needs no reset because the pointers gate it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[REQ_FIFO_IDX-1:0]] <= read_addr_start;
        end
    end

    // FIFO pointers and the sticky overflow flag for requests dropped while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            req_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (read_start && fifo_full) begin
                req_overflow <= 1'b1;
            end
        end
    end

    // Block sequencer: issue bursts, count beats, track errors, pulse block_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            burst         <= '0;
            beat_cnt      <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            block_done    <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr      <= fifo_head;
                        remaining     <= DEPTH_C;
                        burst         <= first_burst;
                        m_axi_araddr  <= fifo_head;
                        m_axi_arlen   <= 8'(first_burst - cnt_t'(1));
                        m_axi_arvalid <= 1'b1;
                        state         <= AR;
                    end
                end
                AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_next;
                        if (m_axi_rresp != 2'b00) begin
                            resp_err <= 1'b1;
                        end
                        if (m_axi_rlast != (beat_next == burst)) begin
                            resp_err <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            remaining <= rem_next;
                            cur_addr  <= addr_next;
                            if (rem_next == '0) begin
                                block_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                burst         <= next_burst;
                                m_axi_araddr  <= addr_next;
                                m_axi_arlen   <= 8'(next_burst - cnt_t'(1));
                                m_axi_arvalid <= 1'b1;
                                state         <= AR;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
